vga_window_resampler: RTL and testbench

//  Frame-synchronous raster walker: crops a runtime-programmable window from the active video area and decimates it by an integer step.

---
 rtl/vga_window_resampler.sv | 156 +++++++++++++++
 tb/tb_vga_window_resampler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_window_resampler.sv
// Frame-synchronous raster walker: crops a programmable window from the active
// video area, decimates it by an integer step and issues frame-buffer read strobes.
module vga_window_resampler #(
  parameter int DW          = 10,
  parameter int NCH         = 3,
  parameter int CW          = 13,
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 628,
  parameter int H_ACT_START = 216,
  parameter int V_ACT_START = 27,
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 600,
  parameter int RD_LEAD     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [CW-1:0]     i_win_x,
  input  logic [CW-1:0]     i_win_y,
  input  logic [CW-1:0]     i_win_w,
  input  logic [CW-1:0]     i_win_h,
  input  logic [3:0]        i_step,
  input  logic              i_mode,
  input  logic [NCH*DW-1:0] i_pix,
  output logic              o_read_request,
  output logic [NCH*DW-1:0] o_pix,
  output logic              o_pix_valid,
  output logic              o_in_win,
  output logic              o_busy,
  output logic              o_finish
);

  localparam int PW = NCH * DW;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] HS  = SW'(H_ACT_START);
  localparam logic [SW-1:0] HE  = SW'(H_ACT_START + H_ACT);
  localparam logic [SW-1:0] VS  = SW'(V_ACT_START);
  localparam logic [SW-1:0] VE  = SW'(V_ACT_START + V_ACT);
  localparam logic [SW-1:0] RDS = SW'(H_ACT_START - RD_LEAD);
  localparam logic [SW-1:0] RDE = SW'(H_ACT_START + H_ACT - RD_LEAD);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_nextState;
  logic [CW-1:0]   r_h, r_v;
  logic [SW-1:0]   r_xStart, r_xEnd, r_yStart, r_yEnd;
  logic [3:0]      r_step;
  logic            r_mode;
  logic [3:0]      r_phase;
  logic [PW-1:0]   r_hold;
  logic [PW-1:0]   r_pix;
  logic            r_valid, r_inWin, r_rd;

  logic            w_launch, w_frameEnd;
  logic [SW-1:0]   w_hExt, w_vExt;
  logic            w_hAct, w_vAct, w_inWin, w_rdCond;
  logic            w_lineStart, w_last, w_sample;
  logic [3:0]      w_phase;
  logic [PW-1:0]   w_holdNow;

  assign w_launch   = (r_state == S_IDLE) && i_start;
  assign w_frameEnd = (r_h == H_LAST) && (r_v == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_nextState = S_RUN;
      S_RUN:   if (w_frameEnd) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Raster counters and the per-frame configuration snapshot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h      <= '0;
      r_v      <= '0;
      r_xStart <= '0;
      r_xEnd   <= '0;
      r_yStart <= '0;
      r_yEnd   <= '0;
      r_step   <= '0;
      r_mode   <= 1'b0;
    end else if (w_launch) begin
      r_h      <= '0;
      r_v      <= '0;
      r_xStart <= HS + SW'(i_win_x);
      r_xEnd   <= HS + SW'(i_win_x) + SW'(i_win_w);
      r_yStart <= VS + SW'(i_win_y);
      r_yEnd   <= VS + SW'(i_win_y) + SW'(i_win_h);
      r_step   <= (i_step == 4'd0) ? 4'd1 : i_step;
      r_mode   <= i_mode;
    end else if (r_state == S_RUN) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_hExt   = SW'(r_h);
  assign w_vExt   = SW'(r_v);
  assign w_hAct   = (w_hExt >= HS) && (w_hExt < HE);
  assign w_vAct   = (w_vExt >= VS) && (w_vExt < VE);
  assign w_inWin  = (r_state == S_RUN) && w_hAct && w_vAct &&
                    (w_hExt >= r_xStart) && (w_hExt < r_xEnd) &&
                    (w_vExt >= r_yStart) && (w_vExt < r_yEnd);
  assign w_rdCond = (r_state == S_RUN) && w_vAct && (w_hExt >= RDS) && (w_hExt < RDE);

  // Horizontal blanking separates lines, so a rising in-window edge marks a window line start.
  assign w_lineStart = w_inWin && !r_inWin;
  assign w_phase     = w_lineStart ? 4'd0 : r_phase;
  assign w_last      = (w_phase == r_step - 4'd1);
  assign w_sample    = w_inWin && w_last;
  assign w_holdNow   = w_lineStart ? '0 : r_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inWin <= 1'b0;
      r_rd    <= 1'b0;
      r_valid <= 1'b0;
      r_pix   <= '0;
      r_phase <= '0;
      r_hold  <= '0;
    end else begin
      r_inWin <= w_inWin;
      r_rd    <= w_rdCond;
      r_valid <= w_sample;
      if (!w_inWin)    r_pix <= '0;
      else if (w_sample) r_pix <= i_pix;
      else if (r_mode) r_pix <= w_holdNow;
      else             r_pix <= '0;
      if (w_inWin) r_phase <= w_last ? 4'd0 : w_phase + 4'd1;
      if (w_sample)         r_hold <= i_pix;
      else if (w_lineStart) r_hold <= '0;
    end
  end

  assign o_read_request = r_rd;
  assign o_pix          = r_pix;
  assign o_pix_valid    = r_valid;
  assign o_in_win       = r_inWin;
  assign o_busy         = (r_state == S_RUN);
  assign o_finish       = (r_state == S_DONE);

endmodule

// File: tb/tb_vga_window_resampler.sv
// Directed bench for vga_window_resampler on a shrunken raster so whole frames
// fit in a short run; expected pixels come from a closed-form window model.
module tb_vga_window_resampler;

  localparam int DW   = 10;
  localparam int NCH  = 3;
  localparam int CW   = 13;
  localparam int HT   = 40;
  localparam int VT   = 20;
  localparam int HS   = 8;
  localparam int VS   = 3;
  localparam int HA   = 24;
  localparam int VA   = 12;
  localparam int LEAD = 2;
  localparam int PW   = NCH * DW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_win_x = '0, i_win_y = '0, i_win_w = '0, i_win_h = '0;
  logic [3:0]    i_step = '0;
  logic          i_mode = 1'b0;
  logic [PW-1:0] i_pix = '0;
  logic          o_read_request, o_pix_valid, o_in_win, o_busy, o_finish;
  logic [PW-1:0] o_pix;

  int compared = 0;
  int mismatched = 0;

  vga_window_resampler #(
    .DW(DW), .NCH(NCH), .CW(CW), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACT_START(HS), .V_ACT_START(VS), .H_ACT(HA), .V_ACT(VA), .RD_LEAD(LEAD)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_win_x(i_win_x), .i_win_y(i_win_y), .i_win_w(i_win_w), .i_win_h(i_win_h),
    .i_step(i_step), .i_mode(i_mode), .i_pix(i_pix),
    .o_read_request(o_read_request), .o_pix(o_pix), .o_pix_valid(o_pix_valid),
    .o_in_win(o_in_win), .o_busy(o_busy), .o_finish(o_finish)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pixAt(input int h, input int v);
    logic [PW-1:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) p[c*DW +: DW] = DW'(v * HT + h + c * 100);
    return p;
  endfunction

  // Runs one frame, checking every cycle; abortAtV >= 0 asserts reset at that line and returns.
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input int stp, input bit md, input int expValidCount,
                               input bit perturb, input int abortAtV);
    int eff, xs, xe, ys, ye, hh, vv, idx, k, vCnt, rCnt;
    logic [PW-1:0] expPix;
    logic expValid, expWin, expRd;
    @(negedge i_clk);
    i_win_x = CW'(x); i_win_y = CW'(y); i_win_w = CW'(w); i_win_h = CW'(h);
    i_step = 4'(stp); i_mode = md; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    eff = (stp == 0) ? 1 : stp;
    xs = HS + x; xe = (HS + x + w < HS + HA) ? HS + x + w : HS + HA;
    ys = VS + y; ye = (VS + y + h < VS + VA) ? VS + y + h : VS + VA;
    expPix = '0; expValid = 1'b0; expWin = 1'b0; expRd = 1'b0;
    vCnt = 0; rCnt = 0;
    for (int n = 0; n < HT * VT; n++) begin
      hh = n % HT;
      vv = n / HT;
      if (abortAtV >= 0 && vv == abortAtV && hh == 0) begin
        i_rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", 64'(o_busy), 64'd0);
        checkOutput("abortFinish", 64'(o_finish), 64'd0);
        checkOutput("abortOutputs", {o_read_request, o_pix, o_pix_valid, o_in_win}, 64'd0);
        return;
      end
      checkOutput("pix", 64'(o_pix), 64'(expPix));
      checkOutput("valid", 64'(o_pix_valid), 64'(expValid));
      checkOutput("inWin", 64'(o_in_win), 64'(expWin));
      checkOutput("readReq", 64'(o_read_request), 64'(expRd));
      checkOutput("busy", 64'(o_busy), 64'd1);
      checkOutput("finishEarly", 64'(o_finish), 64'd0);
      if (o_pix_valid) vCnt++;
      if (o_read_request) rCnt++;
      i_pix = pixAt(hh, vv);
      if (hh >= xs && hh < xe && vv >= ys && vv < ye) begin
        idx = hh - xs;
        expWin = 1'b1;
        expValid = ((idx % eff) == eff - 1);
        if (md) begin
          k = ((idx + 1) / eff) * eff - 1;
          expPix = (k < 0) ? '0 : pixAt(xs + k, vv);
        end else begin
          expPix = expValid ? pixAt(hh, vv) : '0;
        end
      end else begin
        expWin = 1'b0; expValid = 1'b0; expPix = '0;
      end
      expRd = (vv >= VS) && (vv < VS + VA) && (hh >= HS - LEAD) && (hh < HS + HA - LEAD);
      if (perturb && n == 100) begin
        i_win_x = '0; i_win_y = '0; i_win_w = CW'(HA); i_win_h = CW'(VA);
        i_step = 4'd1; i_mode = ~md; i_start = 1'b1;
      end else if (perturb && n == 101) begin
        i_start = 1'b0;
      end
      @(posedge i_clk);
      @(negedge i_clk);
    end
    checkOutput("finish", 64'(o_finish), 64'd1);
    checkOutput("doneBusy", 64'(o_busy), 64'd0);
    checkOutput("donePix", 64'(o_pix), 64'(expPix));
    checkOutput("doneValid", 64'(o_pix_valid), 64'(expValid));
    checkOutput("doneRead", 64'(o_read_request), 64'(expRd));
    if (o_pix_valid) vCnt++;
    if (o_read_request) rCnt++;
    checkOutput("validCount", 64'(vCnt), 64'(expValidCount));
    checkOutput("readCount", 64'(rCnt), 64'(HA * VA));
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("finishPulse", 64'(o_finish), 64'd0);
    checkOutput("idleBusy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    $display("[TB] starting vga_window_resampler bench");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int n = 0; n < 2 * HT * VT; n++) begin
      @(negedge i_clk);
      checkOutput("idleOutputs",
                  {o_read_request, o_pix, o_pix_valid, o_in_win, o_busy, o_finish}, 64'd0);
    end

    applyStimulus(0, 0, HA, VA, 1, 1'b0, HA * VA, 1'b0, -1);
    applyStimulus(6, 3, 12, 6, 3, 1'b0, 24, 1'b0, -1);
    applyStimulus(6, 3, 12, 6, 3, 1'b1, 24, 1'b0, -1);
    applyStimulus(20, 9, 10, 10, 0, 1'b0, 12, 1'b0, -1);
    applyStimulus(5, 5, 0, 4, 1, 1'b0, 0, 1'b0, -1);
    applyStimulus(6, 3, 12, 6, 3, 1'b1, 24, 1'b1, -1);

    applyStimulus(0, 0, HA, VA, 1, 1'b0, HA * VA, 1'b0, VT / 2);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int n = 0; n < 2 * HT; n++) begin
      @(negedge i_clk);
      checkOutput("postAbortFinish", 64'(o_finish), 64'd0);
      checkOutput("postAbortBusy", 64'(o_busy), 64'd0);
    end
    applyStimulus(0, 0, HA, VA, 1, 1'b0, HA * VA, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
